mac_accumulator_4bit: RTL and testbench

//  Downstream consumer of the 4-bit array multiplier's 8-bit product z.

---
 rtl/mac_accumulator_4bit.sv | 106 ++++++++++
 tb/tb_mac_accumulator_4bit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_4bit.sv
// Accumulates unsigned 8-bit products into an ACC_W-bit sum and presents each group on a valid/ready port.
// Define MAC_SATURATE_EN to clamp the sum at 2^ACC_W-1 on overflow instead of wrapping.
module mac_accumulator_4bit #(
    parameter  int unsigned ACC_W     = 12,
    parameter  int unsigned MAX_TERMS = 16,
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [7:0]       in_prod,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_base, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_base, cnt_nx;
    logic             ovf, ovf_base, ovf_nx;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             accept;
    logic             close;

    always_comb begin
        in_ready = 1'b0;
        state_nx = state;

        // A term accepted in IDLE starts a fresh group, so it adds onto zero.
        acc_base = (state == IDLE) ? '0   : acc;
        cnt_base = (state == IDLE) ? '0   : cnt;
        ovf_base = (state == IDLE) ? 1'b0 : ovf;

        sum   = {1'b0, acc_base} + {{(ACC_W - 7){1'b0}}, in_prod};
        carry = sum[ACC_W];
`ifdef MAC_SATURATE_EN
        acc_nx = carry ? '1 : sum[ACC_W-1:0];
`else
        acc_nx = sum[ACC_W-1:0];
`endif
        cnt_nx = cnt_base + 1'b1;
        ovf_nx = ovf_base | carry;
        close  = in_last || (cnt_nx == CNT_W'(MAX_TERMS));

        case (state)
            IDLE, ACCUM: begin
                in_ready = rst_n;
            end
            HOLD: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        accept = in_valid & in_ready;
        if (accept) state_nx = close ? HOLD : ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) state <= IDLE;
        else                 state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            // The presented result fields are deliberately left intact.
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            ovf <= ovf_nx;
            if (close) begin
                out_data  <= acc_nx;
                out_count <= cnt_nx;
                out_ovf   <= ovf_nx;
                out_valid <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// Directed self-checking bench for mac_accumulator_4bit: a 12-bit instance plus a 10-bit one for overflow.
module tb_mac_accumulator_4bit;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_last, out_ready;
    logic [7:0]  in_prod;

    logic        in_ready_a, out_ovf_a, out_valid_a;
    logic [11:0] out_data_a;
    logic [4:0]  out_count_a;

    logic        in_ready_b, out_ovf_b, out_valid_b;
    logic [9:0]  out_data_b;
    logic [4:0]  out_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_accumulator_4bit #(.ACC_W(12), .MAX_TERMS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_prod(in_prod), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_count(out_count_a), .out_ovf(out_ovf_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    mac_accumulator_4bit #(.ACC_W(10), .MAX_TERMS(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_prod(in_prod), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_count(out_count_b), .out_ovf(out_ovf_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_last = 1'b0;
        in_prod = 8'd55; out_ready = 1'b1;

        // Reset held three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready_a), 32'd0);
            chk("rst_out_valid", 32'(out_valid_a), 32'd0);
            chk("rst_out_data", 32'(out_data_a), 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);
        tick();

        // Group 15,30,45 closed by in_last
        in_valid = 1'b1; in_prod = 8'd15; tick();
        in_prod = 8'd30; tick();
        chk("g2_valid_early", 32'(out_valid_a), 32'd0);
        in_prod = 8'd45; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("g2_valid", 32'(out_valid_a), 32'd1);
        chk("g2_data", 32'(out_data_a), 32'd90);
        chk("g2_count", 32'(out_count_a), 32'd3);
        chk("g2_ovf", 32'(out_ovf_a), 32'd0);
        tick();
        chk("g2_handshake", 32'(out_valid_a), 32'd0);

        // 16 x 225 without in_last closes at MAX_TERMS
        in_valid = 1'b1; in_prod = 8'd225;
        for (int i = 0; i < 16; i++) tick();
        chk("g3_valid", 32'(out_valid_a), 32'd1);
        chk("g3_data", 32'(out_data_a), 32'd3600);
        chk("g3_count", 32'(out_count_a), 32'd16);
        chk("g3_ovf", 32'(out_ovf_a), 32'd0);
        chk("g3_in_ready_hold", 32'(in_ready_a), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("g3_handshake", 32'(out_valid_a), 32'd0);

        // 5 x 225 with last: 1125 overflows the 10-bit instance
        in_valid = 1'b1; in_prod = 8'd225;
        for (int i = 0; i < 5; i++) begin
            in_last = (i == 4);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("g4_a_data", 32'(out_data_a), 32'd1125);
        chk("g4_a_ovf", 32'(out_ovf_a), 32'd0);
        chk("g4_b_valid", 32'(out_valid_b), 32'd1);
        chk("g4_b_count", 32'(out_count_b), 32'd5);
`ifdef MAC_SATURATE_EN
        chk("g4_b_data", 32'(out_data_b), 32'd1023);
`else
        chk("g4_b_data", 32'(out_data_b), 32'd101);
`endif
        chk("g4_b_ovf", 32'(out_ovf_b), 32'd1);
        tick();

        // Backpressure: {7 last} held while out_ready is low
        out_ready = 1'b0;
        in_valid = 1'b1; in_prod = 8'd7; in_last = 1'b1; tick();
        in_prod = 8'd50;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("g5_valid", 32'(out_valid_a), 32'd1);
            chk("g5_data", 32'(out_data_a), 32'd7);
            chk("g5_count", 32'(out_count_a), 32'd1);
            chk("g5_in_ready", 32'(in_ready_a), 32'd0);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tick();
        chk("g5_handshake", 32'(out_valid_a), 32'd0);
        chk("g5_data_after", 32'(out_data_a), 32'd7);

        // clear after two terms of 100 discards the partial group
        in_valid = 1'b1; in_prod = 8'd100; tick(); tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        chk("g6_clear_valid", 32'(out_valid_a), 32'd0);
        in_prod = 8'd9; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("g6_valid", 32'(out_valid_a), 32'd1);
        chk("g6_data", 32'(out_data_a), 32'd9);
        chk("g6_count", 32'(out_count_a), 32'd1);

        // clear in HOLD drops out_valid but keeps the presented fields
        out_ready = 1'b0;
        tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        chk("g6_hold_clear_valid", 32'(out_valid_a), 32'd0);
        chk("g6_hold_clear_data", 32'(out_data_a), 32'd9);
        chk("g6_hold_clear_in_ready", 32'(in_ready_a), 32'd1);

        // Reset mid-group loses the group entirely
        out_ready = 1'b1;
        in_valid = 1'b1; in_prod = 8'd20; tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; in_prod = 8'd3; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("g7_data", 32'(out_data_a), 32'd3);
        chk("g7_count", 32'(out_count_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
